// File: rtl/seq_divider.sv
// Sequential non-restoring divider: one quotient bit per cycle, with a fix-up cycle
// for remainder restore and sign correction. Divide-by-zero completes on the next cycle.
module seq_divider #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SIGNED_EN = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic             ctrl_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  // Two guard bits: the shifted partial remainder spans (-2*d, 2*d) with d < 2^WIDTH.
  logic [WIDTH+1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] dvd_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             ovf_q;
  logic             dz_q;

  logic             sgn_in;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             start_ok;
  logic             ovf_in;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] rem_next;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_out;
  logic [WIDTH-1:0] rem_out;

  always_comb begin
    sgn_in   = (SIGNED_EN != 0) && ctrl_signed;
    a_neg    = sgn_in && data_operandA[WIDTH-1];
    b_neg    = sgn_in && data_operandB[WIDTH-1];
    a_mag    = a_neg ? -data_operandA : data_operandA;
    b_mag    = b_neg ? -data_operandB : data_operandB;
    // The FIX cycle doubles as the accept slot so back-to-back divides lose no cycle.
    start_ok = ctrl_DIV && (state_q != StRun);
    ovf_in   = sgn_in && (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);

    shifted  = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
    rem_next = rem_q[WIDTH+1] ? (shifted + {2'b00, dvs_q}) : (shifted - {2'b00, dvs_q});

    rem_fix  = rem_q[WIDTH-1:0] + (rem_q[WIDTH+1] ? dvs_q : '0);
    quo_out  = neg_quo_q ? -quo_q : quo_q;
    rem_out  = neg_rem_q ? -rem_fix : rem_fix;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      dvd_q          <= '0;
      neg_quo_q      <= 1'b0;
      neg_rem_q      <= 1'b0;
      ovf_q          <= 1'b0;
      dz_q           <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state_q)
        StRun: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[WIDTH-2:0], ~rem_next[WIDTH+1]};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= StFix;
        end
        StFix: begin
          if (dz_q) begin
            data_result    <= '1;
            data_remainder <= dvd_q;
            data_exception <= 1'b1;
          end else begin
            data_result    <= quo_out;
            data_remainder <= rem_out;
            data_exception <= ovf_q;
          end
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state_q        <= StIdle;
        end
        default: ;
      endcase

      if (start_ok) begin
        dvd_q     <= data_operandA;
        dvs_q     <= b_mag;
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        ovf_q     <= ovf_in;
        rem_q     <= '0;
        quo_q     <= a_mag;
        cnt_q     <= '0;
        if (data_operandB == '0) begin
          dz_q    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StFix;
        end else begin
          dz_q    <= 1'b0;
          busy    <= 1'b1;
          state_q <= StRun;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a 32-bit signed-capable instance and an 8-bit
// unsigned-only instance, checked against hand-computed quotients and latencies.
module tb_seq_divider;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        div32, sgn32;
  logic [31:0] a32, b32, q32, r32;
  logic        exc32, rdy32, busy32;
  logic        div8, sgn8;
  logic [7:0]  a8, b8, q8, r8;
  logic        exc8, rdy8, busy8;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(32), .SIGNED_EN(1)) u_dut32 (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_DIV      (div32),
    .ctrl_signed   (sgn32),
    .data_operandA (a32),
    .data_operandB (b32),
    .data_result   (q32),
    .data_remainder(r32),
    .data_exception(exc32),
    .data_resultRDY(rdy32),
    .busy          (busy32)
  );

  seq_divider #(.WIDTH(8), .SIGNED_EN(0)) u_dut8 (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_DIV      (div8),
    .ctrl_signed   (sgn8),
    .data_operandA (a8),
    .data_operandB (b8),
    .data_result   (q8),
    .data_remainder(r8),
    .data_exception(exc8),
    .data_resultRDY(rdy8),
    .busy          (busy8)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for rdy32 from the current time, counting rising edges; returns the count.
  task automatic wait_rdy32(input int bound, output int k);
    k = 0;
    while (!rdy32 && k < bound) begin
      @(posedge clock); #1;
      k++;
    end
  endtask

  task automatic run32(input int idx, input vec_t v);
    int k;
    @(negedge clock);
    div32 = 1'b1; sgn32 = v.s; a32 = v.a; b32 = v.b;
    @(posedge clock); #1;
    // Scramble inputs after capture to prove they were registered.
    div32 = 1'b0; sgn32 = ~v.s; a32 = 32'hA5A5_5A5A; b32 = 32'h0000_0003;
    chk($sformatf("v%0d busy", idx), 64'(busy32), 64'(v.lat > 1));
    wait_rdy32(v.lat + 8, k);
    chk($sformatf("v%0d latency", idx), 64'(k), 64'(v.lat));
    chk($sformatf("v%0d quotient", idx), 64'(q32), 64'(v.q));
    chk($sformatf("v%0d remainder", idx), 64'(r32), 64'(v.r));
    chk($sformatf("v%0d exception", idx), 64'(exc32), 64'(v.e));
    @(posedge clock); #1;
    chk($sformatf("v%0d pulse end", idx), 64'(rdy32), 64'(0));
    chk($sformatf("v%0d hold", idx), {q32, r32}, {v.q, v.r});
  endtask

  initial begin
    int k;
    vecs[0]  = '{1'b0, 32'd7,         32'd2,         32'd3,         32'd1,         1'b0, 33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33};
    vecs[2]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 33};
    vecs[3]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 33};
    vecs[5]  = '{1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1,         1'b0, 33};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b1, 33};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33};
    vecs[8]  = '{1'b1, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1};
    vecs[9]  = '{1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 33};
    vecs[10] = '{1'b0, 32'd5,         32'd10,        32'd0,         32'd5,         1'b0, 33};
    vecs[11] = '{1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0,         1'b0, 33};
    vecs[12] = '{1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33};
    vecs[13] = '{1'b0, 32'hDEAD_BEEF, 32'h10,        32'h0DEA_DBEE, 32'hF,         1'b0, 33};

    reset_n = 1'b0;
    div32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    div8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
    #12;
    chk("reset outputs32", {q32, r32, 29'd0, exc32, rdy32, busy32}, 64'd0);
    chk("reset outputs8", {48'd0, q8, r8}, 64'd0);
    chk("reset flags8", {61'd0, exc8, rdy8, busy8}, 64'd0);
    @(negedge clock); reset_n = 1'b1;

    for (int i = 0; i < 14; i++) run32(i, vecs[i]);

    // Start held through busy: the operand change is ignored; restart lands on the RDY edge.
    @(negedge clock);
    div32 = 1'b1; sgn32 = 1'b0; a32 = 32'd7; b32 = 32'd2;
    @(posedge clock); #1;
    a32 = 32'd100; b32 = 32'd3;
    wait_rdy32(40, k);
    chk("held first latency", 64'(k), 64'd33);
    chk("held first result", {q32, r32}, {32'd3, 32'd1});
    chk("held restart busy", 64'(busy32), 64'd1);
    div32 = 1'b0;
    @(posedge clock); #1;
    begin
      int k2;
      wait_rdy32(40, k2);
      chk("held second latency", 64'(k + 1 + k2), 64'd66);
    end
    chk("held second result", {q32, r32}, {32'd33, 32'd1});

    // Reset ten edges into a divide, then a start on the first edge after release.
    @(negedge clock);
    div32 = 1'b1; a32 = 32'd7; b32 = 32'd2;
    @(posedge clock); #1;
    div32 = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("midrun reset data", {q32, r32}, 64'd0);
    chk("midrun reset flags", {61'd0, exc32, rdy32, busy32}, 64'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1; div32 = 1'b1; a32 = 32'd9; b32 = 32'd4;
    @(posedge clock); #1;
    div32 = 1'b0;
    chk("post reset busy", 64'(busy32), 64'd1);
    wait_rdy32(40, k);
    chk("post reset latency", 64'(k), 64'd33);
    chk("post reset result", {q32, r32}, {32'd2, 32'd1});

    // 8-bit unsigned-only instance: ctrl_signed must be ignored.
    @(negedge clock);
    div8 = 1'b1; sgn8 = 1'b1; a8 = 8'd255; b8 = 8'd16;
    @(posedge clock); #1;
    div8 = 1'b0;
    k = 0;
    while (!rdy8 && k < 20) begin @(posedge clock); #1; k++; end
    chk("w8 latency", 64'(k), 64'd9);
    chk("w8 result", {48'd0, q8, r8}, {48'd0, 8'd15, 8'd15});
    chk("w8 exception", 64'(exc8), 64'd0);
    @(negedge clock);
    div8 = 1'b1; sgn8 = 1'b1; a8 = 8'h80; b8 = 8'hFF;
    @(posedge clock); #1;
    div8 = 1'b0;
    k = 0;
    while (!rdy8 && k < 20) begin @(posedge clock); #1; k++; end
    chk("w8 min latency", 64'(k), 64'd9);
    chk("w8 min result", {48'd0, q8, r8}, {48'd0, 8'd0, 8'h80});
    chk("w8 min exception", 64'(exc8), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
